collision_score: RTL and testbench



---
 rtl/game_pkg.sv | 29 ++
 rtl/collision_score_bar_hit_check.sv | 43 ++++
 rtl/collision_score.sv | 194 +++++++++++++++++++
 tb/tb_collision_score.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and screen geometry for environment, rules stage and renderer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int NUM_BARS = 8;

    // Pixel coordinate on the 640x480 screen
    typedef logic [9:0] coord_t;

    // Game-rules state machine
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_SCAN = 3'd2,
        ST_DEAD = 3'd3,
        ST_WIN  = 3'd4
    } state_t;

    // Score accumulation that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {5'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/collision_score_bar_hit_check.sv
// Bird-vs-bar test for one bar column: collision with the solid part, and fully-passed flag.
// Latency: combinational.
// Backpressure: none; evaluated every cycle on whatever bar the caller selects.
module bar_hit_check
    import game_pkg::*;
#(
    parameter int BIRD_SIZE = 16,
    parameter int BAR_X0    = 80,
    parameter int BAR_PITCH = 70,
    parameter int BAR_W     = 20
) (
    input  coord_t     bird_x,
    input  coord_t     bird_y,
    input  logic [2:0] col,
    input  coord_t     pos,
    input  coord_t     op,
    output logic       hit,
    output logic       clear_right
);

    // All sums carried at 11 bits so right/bottom edges near 640/480 never wrap
    logic [10:0] xl;
    logic [10:0] xr;
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] open_top;
    logic [10:0] open_bot;
    logic        overlap;

    // Column geometry and box comparisons for the selected bar
    always_comb begin
        xl          = 11'(BAR_X0) + 11'(col) * 11'(BAR_PITCH);
        xr          = xl + 11'(BAR_W) - 11'd1;
        bx          = {1'b0, bird_x};
        by          = {1'b0, bird_y};
        open_top    = {1'b0, pos};
        open_bot    = {1'b0, pos} + {1'b0, op};
        overlap     = (bx <= xr) && (bx + 11'(BIRD_SIZE) - 11'd1 >= xl);
        hit         = overlap && ((by < open_top) || (by + 11'(BIRD_SIZE) > open_bot));
        clear_right = (bx > xr);
    end

endmodule

// File: rtl/collision_score.sv
// Game rules: per-frame snapshot, one-bar-per-cycle collision/pass scan, play/dead/win FSM.
// Latency: frame_tick at edge T -> bars checked T+1..T+8 -> state/score/flags register at T+9.
// Backpressure: drives pause to freeze the environment outside PLAY/SCAN; extra ticks while busy are dropped.
module collision_score
    import game_pkg::*;
#(
    parameter int                    BIRD_SIZE   = 16,
    parameter int                    BAR_X0      = 80,
    parameter int                    BAR_PITCH   = 70,
    parameter int                    BAR_W       = 20,
    parameter logic [NUM_BARS-1:0]   ACTIVE_MASK = 8'b0111_1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [9:0] bar_pos1,
    input  logic [9:0] bar_pos2,
    input  logic [9:0] bar_pos3,
    input  logic [9:0] bar_pos4,
    input  logic [9:0] bar_pos5,
    input  logic [9:0] bar_pos6,
    input  logic [9:0] bar_pos7,
    input  logic [9:0] bar_pos8,
    input  logic [9:0] bar_op1,
    input  logic [9:0] bar_op2,
    input  logic [9:0] bar_op3,
    input  logic [9:0] bar_op4,
    input  logic [9:0] bar_op5,
    input  logic [9:0] bar_op6,
    input  logic [9:0] bar_op7,
    input  logic [9:0] bar_op8,
    output logic [7:0] score,
    output logic [9:0] level,
    output logic       pause,
    output logic       game_over,
    output logic       level_done
);

    state_t                state;
    state_t                state_nxt;

    coord_t                bar_pos_in [NUM_BARS];
    coord_t                bar_op_in  [NUM_BARS];

    coord_t                snap_x;
    coord_t                snap_y;
    coord_t                snap_pos   [NUM_BARS];
    coord_t                snap_op    [NUM_BARS];

    // scan_idx 0..7 selects the bar being checked; 8 is the resolve cycle
    logic [3:0]            scan_idx;
    logic [2:0]            bar_sel;
    logic                  scan_last;
    logic                  hit_acc;
    logic [3:0]            pend_cnt;
    logic [NUM_BARS-1:0]   passed;

    logic                  bar_hit;
    logic                  bar_clear;
    logic                  bar_live;
    logic                  edge_hit;
    logic                  win_pos;

    assign bar_pos_in = '{bar_pos1, bar_pos2, bar_pos3, bar_pos4,
                          bar_pos5, bar_pos6, bar_pos7, bar_pos8};
    assign bar_op_in  = '{bar_op1, bar_op2, bar_op3, bar_op4,
                          bar_op5, bar_op6, bar_op7, bar_op8};

    assign bar_sel   = scan_idx[2:0];
    assign scan_last = (scan_idx == 4'd8);
    assign bar_live  = ACTIVE_MASK[bar_sel];
    // Floor test rides along with bar 0 so it costs no extra cycle
    assign edge_hit  = (scan_idx == 4'd0) &&
                       ({1'b0, snap_y} + 11'(BIRD_SIZE) > 11'(SCREEN_H));
    assign win_pos   = ({1'b0, snap_x} >= 11'(SCREEN_W - BIRD_SIZE));

    bar_hit_check #(
        .BIRD_SIZE (BIRD_SIZE),
        .BAR_X0    (BAR_X0),
        .BAR_PITCH (BAR_PITCH),
        .BAR_W     (BAR_W)
    ) u_bar_hit_check (
        .bird_x      (snap_x),
        .bird_y      (snap_y),
        .col         (bar_sel),
        .pos         (snap_pos[bar_sel]),
        .op          (snap_op[bar_sel]),
        .hit         (bar_hit),
        .clear_right (bar_clear)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start leaves the paused states, tick starts a scan, resolve picks the outcome
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DEAD, ST_WIN: begin
                if (start) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_last) begin
                    if (hit_acc)      state_nxt = ST_DEAD;
                    else if (win_pos) state_nxt = ST_WIN;
                    else              state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; environment runs only while playing or scanning
    always_comb begin
        pause     = 1'b1;
        game_over = 1'b0;
        case (state)
            ST_PLAY, ST_SCAN: pause     = 1'b0;
            ST_DEAD:          game_over = 1'b1;
            default:          pause     = 1'b1;
        endcase
    end

    // Snapshot, scan accumulators, score and level bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x     <= '0;
            snap_y     <= '0;
            for (int i = 0; i < NUM_BARS; i++) begin
                snap_pos[i] <= '0;
                snap_op[i]  <= '0;
            end
            scan_idx   <= '0;
            hit_acc    <= 1'b0;
            pend_cnt   <= '0;
            passed     <= '0;
            score      <= '0;
            level      <= 10'd1;
            level_done <= 1'b0;
        end else begin
            level_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DEAD, ST_WIN: begin
                    if (start) begin
                        passed <= '0;
                        if (state != ST_WIN)  score <= '0;
                        if (state == ST_DEAD) level <= 10'd1;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        snap_x   <= bird_x;
                        snap_y   <= bird_y;
                        snap_pos <= bar_pos_in;
                        snap_op  <= bar_op_in;
                        scan_idx <= '0;
                        hit_acc  <= 1'b0;
                        pend_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!scan_last) begin
                        scan_idx <= scan_idx + 4'd1;
                        if (edge_hit || (bar_live && bar_hit)) hit_acc <= 1'b1;
                        if (bar_live && bar_clear && !passed[bar_sel]) begin
                            passed[bar_sel] <= 1'b1;
                            pend_cnt        <= pend_cnt + 4'd1;
                        end
                    end else if (!hit_acc) begin
                        score <= sat_add8(score, pend_cnt);
                        if (win_pos) begin
                            level      <= (level == 10'h3FF) ? 10'd1 : level + 10'd1;
                            level_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_score.sv
module tb_collision_score;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic [9:0] bird_x;
    logic [9:0] bird_y;
    logic [9:0] bar_pos [8];
    logic [9:0] bar_op  [8];
    logic [7:0] score;
    logic [9:0] level;
    logic       pause;
    logic       game_over;
    logic       level_done;

    int tests_run    = 0;
    int tests_failed = 0;

    collision_score dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .bar_pos1   (bar_pos[0]),
        .bar_pos2   (bar_pos[1]),
        .bar_pos3   (bar_pos[2]),
        .bar_pos4   (bar_pos[3]),
        .bar_pos5   (bar_pos[4]),
        .bar_pos6   (bar_pos[5]),
        .bar_pos7   (bar_pos[6]),
        .bar_pos8   (bar_pos[7]),
        .bar_op1    (bar_op[0]),
        .bar_op2    (bar_op[1]),
        .bar_op3    (bar_op[2]),
        .bar_op4    (bar_op[3]),
        .bar_op5    (bar_op[4]),
        .bar_op6    (bar_op[5]),
        .bar_op7    (bar_op[6]),
        .bar_op8    (bar_op[7]),
        .score      (score),
        .level      (level),
        .pause      (pause),
        .game_over  (game_over),
        .level_done (level_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge right after the capturing edge T
    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        tests_run++;
        if (level !== 10'd1) begin tests_failed++; $display("FAIL reset_level got %0d want 1", level); end
        tests_run++;
        if (score !== 8'd0) begin tests_failed++; $display("FAIL reset_score got %0d want 0", score); end
        tests_run++;
        if (pause !== 1'b1 || game_over !== 1'b0 || level_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got pause=%b go=%b ld=%b want 1/0/0", pause, game_over, level_done);
        end
        rst_n = 1'b1;
        wait_cycles(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (pause !== 1'b0) begin tests_failed++; $display("FAIL start_pause got %b want 0", pause); end
    endtask

    task automatic test_bar_collision();
        bird_x = 10'd150;
        bird_y = 10'd200;
        pulse_tick();
        wait_cycles(8);
        tests_run++;
        if (game_over !== 1'b0 || pause !== 1'b0) begin
            tests_failed++;
            $display("FAIL hit_early got go=%b pause=%b want 0/0", game_over, pause);
        end
        wait_cycles(1);
        tests_run++;
        if (game_over !== 1'b1 || pause !== 1'b1 || score !== 8'd0) begin
            tests_failed++;
            $display("FAIL hit_dead got go=%b pause=%b score=%0d want 1/1/0", game_over, pause, score);
        end
    endtask

    task automatic test_clean_pass();
        pulse_start();
        bird_x = 10'd150;
        bird_y = 10'd250;
        pulse_tick();
        wait_cycles(9);
        tests_run++;
        if (game_over !== 1'b0 || score !== 8'd0 || pause !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_inside got go=%b score=%0d pause=%b want 0/0/0", game_over, score, pause);
        end
        bird_x = 10'd170;
        pulse_tick();
        wait_cycles(8);
        tests_run++;
        if (score !== 8'd0) begin tests_failed++; $display("FAIL pass_early got %0d want 0", score); end
        wait_cycles(1);
        tests_run++;
        if (score !== 8'd1) begin tests_failed++; $display("FAIL pass_score got %0d want 1", score); end
        bird_x = 10'd171;
        pulse_tick();
        wait_cycles(9);
        tests_run++;
        if (score !== 8'd1 || level !== 10'd1) begin
            tests_failed++;
            $display("FAIL pass_once got score=%0d level=%0d want 1/1", score, level);
        end
    endtask

    task automatic test_retick_during_scan();
        bird_x = 10'd240;
        pulse_tick();
        bird_x = 10'd310;
        bird_y = 10'd100;
        wait_cycles(2);
        frame_tick = 1'b1;
        wait_cycles(1);
        frame_tick = 1'b0;
        wait_cycles(6);
        tests_run++;
        if (score !== 8'd2) begin tests_failed++; $display("FAIL retick_score got %0d want 2", score); end
        wait_cycles(12);
        tests_run++;
        if (score !== 8'd2 || pause !== 1'b0) begin
            tests_failed++;
            $display("FAIL retick_later got score=%0d pause=%b want 2/0", score, pause);
        end
    endtask

    task automatic test_floor();
        bird_x = 10'd20;
        bird_y = 10'd470;
        pulse_tick();
        wait_cycles(8);
        tests_run++;
        if (game_over !== 1'b0) begin tests_failed++; $display("FAIL floor_early got %b want 0", game_over); end
        wait_cycles(1);
        tests_run++;
        if (game_over !== 1'b1) begin tests_failed++; $display("FAIL floor_dead got %b want 1", game_over); end
    endtask

    task automatic test_level_complete();
        pulse_start();
        tests_run++;
        if (score !== 8'd0 || level !== 10'd1 || pause !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart got score=%0d level=%0d pause=%b want 0/1/0", score, level, pause);
        end
        bird_x = 10'd624;
        bird_y = 10'd250;
        pulse_tick();
        wait_cycles(8);
        tests_run++;
        if (level_done !== 1'b0 || level !== 10'd1) begin
            tests_failed++;
            $display("FAIL win_early got ld=%b level=%0d want 0/1", level_done, level);
        end
        wait_cycles(1);
        tests_run++;
        if (level_done !== 1'b1 || level !== 10'd2 || pause !== 1'b1 || score !== 8'd6) begin
            tests_failed++;
            $display("FAIL win_resolve got ld=%b level=%0d pause=%b score=%0d want 1/2/1/6",
                     level_done, level, pause, score);
        end
        wait_cycles(1);
        tests_run++;
        if (level_done !== 1'b0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL win_pulse got ld=%b go=%b want 0/0", level_done, game_over);
        end
        pulse_start();
        tests_run++;
        if (pause !== 1'b0 || score !== 8'd6 || level !== 10'd2) begin
            tests_failed++;
            $display("FAIL continue got pause=%b score=%0d level=%0d want 0/6/2", pause, score, level);
        end
    endtask

    task automatic test_reset_mid_scan();
        bird_x = 10'd400;
        bird_y = 10'd250;
        pulse_tick();
        wait_cycles(4);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (score !== 8'd0 || level !== 10'd1 || pause !== 1'b1 || game_over !== 1'b0 || level_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midscan_reset got score=%0d level=%0d pause=%b go=%b ld=%b want 0/1/1/0/0",
                     score, level, pause, game_over, level_done);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        pulse_tick();
        wait_cycles(12);
        tests_run++;
        if (pause !== 1'b1 || score !== 8'd0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignores_tick got pause=%b score=%0d go=%b want 1/0/0", pause, score, game_over);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        bird_x     = 10'd0;
        bird_y     = 10'd0;
        // Full-height openings everywhere except bar 1, so only bar 1 and the floor can kill
        for (int i = 0; i < 8; i++) begin
            bar_pos[i] = 10'd0;
            bar_op[i]  = 10'd480;
        end
        bar_pos[1] = 10'd240;
        bar_op[1]  = 10'd60;

        test_reset();
        test_bar_collision();
        test_clean_pass();
        test_retick_during_scan();
        test_floor();
        test_level_complete();
        test_reset_mid_scan();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
